// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default operand width.
// Pure declarations; no logic, no latency, no flow control.
package adder_pkg;

    localparam int ADDER_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/logic_full_adder.sv
// Single-bit full adder cell, purely combinational.
// Zero latency; no flow control.
module logic_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder cell reused LSB first, carry held in a flop; done WIDTH clocks after accept.
// start is only sampled in IDLE; requests during RUN/DONE are dropped, giving one add per WIDTH+2 clocks at best.
module serial_adder_ctrl
    import adder_pkg::*;
#(
    parameter  int WIDTH = ADDER_WIDTH,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset_p,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    // Holds the WIDTH-1 sum bits produced before the final one, newest at the MSB.
    logic [WIDTH-2:0]   r_res;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;

    logic               w_s;
    logic               w_c;
    logic               w_accept;
    logic               w_last;

    logic_full_adder u_cell (
        .a    (r_a_sh[0]),
        .b    (r_b_sh[0]),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_c)
    );

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_cnt == LAST_CNT) begin
                    w_last       = 1'b1;
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            r_a_sh  <= a_in;
            r_b_sh  <= b_in;
            r_carry <= cin;
            r_cnt   <= '0;
        end else if (r_state == ST_RUN) begin
            r_a_sh  <= r_a_sh >> 1;
            r_b_sh  <= r_b_sh >> 1;
            r_carry <= w_c;
            r_res   <= (WIDTH-1)'({w_s, r_res} >> 1);
            r_cnt   <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_sum  <= {w_s, r_res};
                r_cout <= w_c;
            end
        end
    end

    assign busy = (r_state == ST_RUN);
    assign done = (r_state == ST_DONE);
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8) against an arithmetic reference a+b+cin.
// Directed scenarios followed by a randomized sweep; outputs sampled on the falling edge.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset_p;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;
    bit mon_en   = 1'b0;
    logic prev_done = 1'b0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_p (reset_p),
        .start   (start),
        .a_in    (a_in),
        .b_in    (b_in),
        .cin     (cin),
        .busy    (busy),
        .done    (done),
        .sum     (sum),
        .cout    (cout)
    );

    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    endfunction

    // Protocol monitor: done never overlaps busy and never lasts more than one cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            n_checks++;
            if (done && busy) begin
                n_fail++;
                $display("FAIL done_busy_overlap: done=%b busy=%b required not both 1", done, busy);
            end
            n_checks++;
            if (done && prev_done) begin
                n_fail++;
                $display("FAIL done_width: done high 2 cycles in a row, required 1");
            end
            if (done) n_done++;
        end
        prev_done = done;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives one request from IDLE and waits (bounded) for done; leaves the DUT back in IDLE.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          output int lat, output int nbusy, output bit ok,
                          output logic [W-1:0] r_sum, output logic r_cout);
        a_in  = a;
        b_in  = b;
        cin   = c;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        nbusy = busy ? 1 : 0;
        while (!done && lat < 64) begin
            @(negedge clk);
            lat++;
            if (busy) nbusy++;
        end
        ok     = done;
        r_sum  = sum;
        r_cout = cout;
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset_p = 1'b1;
        start   = 1'b0;
        a_in    = '0;
        b_in    = '0;
        cin     = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (sum !== '0)    begin n_fail++; $display("FAIL reset_sum: got %h expected 00", sum); end
        n_checks++; if (cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout: got %b expected 0", cout); end
        reset_p = 1'b0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b expected 0", busy); end
        mon_en = 1'b1;
    endtask

    task automatic test_directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        int lat, nbusy;
        bit ok;
        logic [W-1:0] s;
        logic co;
        logic [W:0] exp;
        exp = ref_add(a, b, c);
        run_op(a, b, c, lat, nbusy, ok, s, co);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL %s_timeout: no done within 64 cycles", name); end
        n_checks++;
        if (lat - 1 !== W) begin n_fail++; $display("FAIL %s_latency: got %0d clocks expected %0d", name, lat - 1, W); end
        n_checks++;
        if (nbusy !== W) begin n_fail++; $display("FAIL %s_busy_cycles: got %0d expected %0d", name, nbusy, W); end
        n_checks++;
        if (s !== exp[W-1:0]) begin n_fail++; $display("FAIL %s_sum: got %h expected %h", name, s, exp[W-1:0]); end
        n_checks++;
        if (co !== exp[W]) begin n_fail++; $display("FAIL %s_cout: got %b expected %b", name, co, exp[W]); end
    endtask

    task automatic test_back_to_back;
        int g;
        a_in  = 8'hFF;
        b_in  = 8'hFF;
        cin   = 1'b1;
        start = 1'b1;
        g = 0;
        while (!done && g < 64) begin @(negedge clk); g++; end
        n_checks++; if (!done) begin n_fail++; $display("FAIL b2b_first_timeout: no done"); end
        n_checks++; if (sum !== 8'hFF) begin n_fail++; $display("FAIL b2b_first_sum: got %h expected ff", sum); end
        n_checks++; if (cout !== 1'b1) begin n_fail++; $display("FAIL b2b_first_cout: got %b expected 1", cout); end
        a_in = 8'h00;
        b_in = 8'h00;
        cin  = 1'b0;
        g = 0;
        do begin @(negedge clk); g++; end while (!done && g < 64);
        start = 1'b0;
        n_checks++;
        if (g !== W + 2) begin n_fail++; $display("FAIL b2b_spacing: got %0d clocks expected %0d", g, W + 2); end
        n_checks++; if (sum !== 8'h00) begin n_fail++; $display("FAIL b2b_second_sum: got %h expected 00", sum); end
        n_checks++; if (cout !== 1'b0) begin n_fail++; $display("FAIL b2b_second_cout: got %b expected 0", cout); end
        @(negedge clk);
    endtask

    task automatic test_ignore_start;
        int n0;
        n0    = n_done;
        a_in  = 8'h12;
        b_in  = 8'h34;
        cin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        a_in  = 8'hAA;
        b_in  = 8'h55;
        @(negedge clk);
        start = 1'b0;
        repeat (3 * W) @(negedge clk);
        n_checks++;
        if (n_done - n0 !== 1) begin n_fail++; $display("FAIL ignore_done_count: got %0d expected 1", n_done - n0); end
        n_checks++; if (sum !== 8'h46) begin n_fail++; $display("FAIL ignore_sum: got %h expected 46", sum); end
        n_checks++; if (cout !== 1'b0) begin n_fail++; $display("FAIL ignore_cout: got %b expected 0", cout); end
    endtask

    task automatic test_reset_mid_run;
        int n0;
        a_in  = 8'h80;
        b_in  = 8'h80;
        cin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_busy: got %b expected 1", busy); end
        n0 = n_done;
        #1 reset_p = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b expected 0", done); end
        n_checks++; if (sum !== '0)    begin n_fail++; $display("FAIL midrst_sum: got %h expected 00", sum); end
        n_checks++; if (cout !== 1'b0) begin n_fail++; $display("FAIL midrst_cout: got %b expected 0", cout); end
        repeat (2) @(negedge clk);
        reset_p = 1'b0;
        repeat (2 * W) @(negedge clk);
        n_checks++;
        if (n_done !== n0) begin n_fail++; $display("FAIL midrst_no_done: got %0d pulses expected 0", n_done - n0); end
        n_checks++; if (sum !== '0) begin n_fail++; $display("FAIL midrst_sum_held: got %h expected 00", sum); end
        test_directed("after_reset", 8'h01, 8'h02, 1'b0);
    endtask

    task automatic test_random;
        int lat, nbusy;
        bit ok;
        logic [W-1:0] a, b, s;
        logic c, co;
        logic [W:0] exp;
        for (int i = 0; i < 1000; i++) begin
            a   = W'($urandom);
            b   = W'($urandom);
            c   = 1'($urandom_range(0, 1));
            exp = ref_add(a, b, c);
            run_op(a, b, c, lat, nbusy, ok, s, co);
            n_checks++;
            if (!ok) begin n_fail++; $display("FAIL rand_timeout: op %0d no done", i); end
            n_checks++;
            if (lat - 1 !== W) begin n_fail++; $display("FAIL rand_latency: op %0d got %0d expected %0d", i, lat - 1, W); end
            n_checks++;
            if ({co, s} !== exp) begin
                n_fail++;
                $display("FAIL rand_result: op %0d %h+%h+%b got %h expected %h", i, a, b, c, {co, s}, exp);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_directed("basic", 8'h5A, 8'h3C, 1'b0);
        test_directed("ripple", 8'hFF, 8'h01, 1'b0);
        test_back_to_back();
        test_ignore_start();
        test_reset_mid_run();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
